tx_metaframer: RTL and testbench



---
 rtl/tx_metaframer.sv | 96 +++++++++
 tb/tb_tx_metaframer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/tx_metaframer.sv
`default_nettype none
// ============================================================================
//  Module      : tx_metaframer
//  Description : Single-lane Interlaken-style TX framer: sync, scrambler
//                state, skip, payload and diagnostic words per metaframe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_metaframer #(
    parameter int          META_FRAME_LEN = 16,
    parameter logic [63:0] IDLE_WORD      = 64'hAAAA_AAAA_AAAA_AAAA,
    parameter logic [63:0] SYNC_WORD      = 64'h78F6_78F6_78F6_78F6,
    parameter logic [63:0] SKIP_WORD      = 64'h1E1E_1E1E_1E1E_1E1E
) (
    input  logic        USER_CLK,
    input  logic        SYSTEM_RESET_N,
    input  logic [63:0] DATA_IN,
    input  logic        DATA_IN_VALID,
    output logic        DATA_IN_READY,
    input  logic [57:0] SCRAM_STATE,
    input  logic [1:0]  LANE_STATUS,
    input  logic        SKIP_REQ,
    output logic        SKIP_ACK,
    output logic [63:0] DATA_OUT,
    output logic [1:0]  HEADER_OUT,
    output logic        FRAME_START
);

    localparam int          CW        = $clog2(META_FRAME_LEN);
    localparam logic [CW-1:0] C_LAST  = CW'(META_FRAME_LEN - 1);
    localparam logic [CW-1:0] C_LASTP = CW'(META_FRAME_LEN - 2);

    logic [CW-1:0] slot_q, slot_d;
    logic          skip_q, skip_d;
    logic [63:0]   data_q, data_d;
    logic [1:0]    hdr_q,  hdr_d;
    logic          fs_q,   fs_d;
    logic          ack_q,  ack_d;
    logic          w_payload;

    assign w_payload     = (slot_q >= CW'(3)) && (slot_q <= C_LASTP);
    // Ready depends only on registered state (and reset), never on VALID.
    assign DATA_IN_READY = SYSTEM_RESET_N & w_payload & ~skip_q;

    always_comb begin
        slot_d = (slot_q == C_LAST) ? '0 : slot_q + CW'(1);
        // A request arriving while the flag is consumed re-arms it.
        if (w_payload && skip_q) skip_d = SKIP_REQ;
        else                     skip_d = skip_q | SKIP_REQ;

        data_d = IDLE_WORD;
        hdr_d  = 2'b10;
        fs_d   = 1'b0;
        ack_d  = 1'b0;
        if (slot_q == CW'(0)) begin
            data_d = SYNC_WORD;
            fs_d   = 1'b1;
        end else if (slot_q == CW'(1)) begin
            data_d = {6'b001010, SCRAM_STATE};
        end else if (slot_q == CW'(2)) begin
            data_d = SKIP_WORD;
        end else if (slot_q == C_LAST) begin
            data_d = {6'b011001, 24'h0, LANE_STATUS, 32'h0};
        end else if (skip_q) begin
            data_d = SKIP_WORD;
            ack_d  = 1'b1;
        end else if (DATA_IN_VALID) begin
            data_d = DATA_IN;
            hdr_d  = 2'b01;
        end
    end

    always_ff @(posedge USER_CLK) begin
        if (!SYSTEM_RESET_N) begin
            slot_q <= '0;
            skip_q <= 1'b0;
            data_q <= IDLE_WORD;
            hdr_q  <= 2'b10;
            fs_q   <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            slot_q <= slot_d;
            skip_q <= skip_d;
            data_q <= data_d;
            hdr_q  <= hdr_d;
            fs_q   <= fs_d;
            ack_q  <= ack_d;
        end
    end

    assign DATA_OUT    = data_q;
    assign HEADER_OUT  = hdr_q;
    assign FRAME_START = fs_q;
    assign SKIP_ACK    = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_metaframer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_metaframer
//  Description : Directed self-checking bench for tx_metaframer (LEN = 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_metaframer;

    localparam logic [63:0] C_IDLE = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] C_SYNC = 64'h78F6_78F6_78F6_78F6;
    localparam logic [63:0] C_SKIP = 64'h1E1E_1E1E_1E1E_1E1E;

    logic        clk;
    logic        rst_n;
    logic [63:0] data_in;
    logic        valid;
    logic        ready;
    logic [57:0] scram;
    logic [1:0]  lane;
    logic        skip_req;
    logic        skip_ack;
    logic [63:0] data_out;
    logic [1:0]  hdr_out;
    logic        frame_start;

    int tests    = 0;
    int failures = 0;
    int rdy_cnt  = 0;
    int step_no  = 0;

    tx_metaframer #(
        .META_FRAME_LEN (8),
        .IDLE_WORD      (C_IDLE),
        .SYNC_WORD      (C_SYNC),
        .SKIP_WORD      (C_SKIP)
    ) dut (
        .USER_CLK       (clk),
        .SYSTEM_RESET_N (rst_n),
        .DATA_IN        (data_in),
        .DATA_IN_VALID  (valid),
        .DATA_IN_READY  (ready),
        .SCRAM_STATE    (scram),
        .LANE_STATUS    (lane),
        .SKIP_REQ       (skip_req),
        .SKIP_ACK       (skip_ack),
        .DATA_OUT       (data_out),
        .HEADER_OUT     (hdr_out),
        .FRAME_START    (frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL step %0d %s: observed %h expected %h", step_no, tag, obs, exp);
        end
    endtask

    // One clock: check READY for the coming edge, then the registered outputs.
    task automatic step(input logic exp_rdy, input logic [63:0] exp_data,
                        input logic [1:0] exp_hdr, input logic exp_fs, input logic exp_ack);
        logic acc;
        #1;
        chk("ready", 64'(ready), 64'(exp_rdy));
        if (ready === 1'b1) rdy_cnt++;
        acc = ready & valid;
        @(posedge clk);
        #1;
        step_no++;
        chk("data", data_out, exp_data);
        chk("header", 64'(hdr_out), 64'(exp_hdr));
        chk("frame_start", 64'(frame_start), 64'(exp_fs));
        chk("skip_ack", 64'(skip_ack), 64'(exp_ack));
        if (acc) data_in = data_in + 64'd1;
    endtask

    // Full 8-slot metaframe with no skip activity.
    task automatic frame(input logic v, input logic [63:0] first,
                         input logic [57:0] sc, input logic [1:0] ls);
        rdy_cnt = 0;
        valid   = v;
        step(1'b0, C_SYNC, 2'b10, 1'b1, 1'b0);
        scram = sc;
        step(1'b0, {6'b001010, sc}, 2'b10, 1'b0, 1'b0);
        scram = '0;
        step(1'b0, C_SKIP, 2'b10, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (v) step(1'b1, first + 64'(k), 2'b01, 1'b0, 1'b0);
            else   step(1'b1, C_IDLE, 2'b10, 1'b0, 1'b0);
        end
        lane = ls;
        step(1'b0, {6'b011001, 24'h0, ls, 32'h0}, 2'b10, 1'b0, 1'b0);
        lane = '0;
        chk("ready_count", 64'(rdy_cnt), 64'd4);
    endtask

    initial begin
        rst_n    = 1'b0;
        data_in  = 64'd1;
        valid    = 1'b0;
        scram    = '0;
        lane     = '0;
        skip_req = 1'b0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_data", data_out, C_IDLE);
        chk("rst_header", 64'(hdr_out), 64'(2'b10));
        chk("rst_fs", 64'(frame_start), 64'd0);
        chk("rst_ack", 64'(skip_ack), 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);

        // Streaming data: frames carry 1..4 and 5..8
        rst_n = 1'b1;
        frame(1'b1, 64'd1, 58'h0, 2'b00);
        chk("scram_const", 64'h2800000000000000, {6'b001010, 58'h0});
        frame(1'b1, 64'd5, 58'h0, 2'b00);

        // No valid data: idle fill
        frame(1'b0, 64'd0, 58'h0, 2'b00);

        // Scrambler state / lane status sampled in their own slots
        frame(1'b0, 64'd0, 58'h123, 2'b11);

        // Skip pulse in slot 3; held word 10 goes out in slot 5
        valid = 1'b1;
        step(1'b0, C_SYNC, 2'b10, 1'b1, 1'b0);
        step(1'b0, 64'h2800000000000000, 2'b10, 1'b0, 1'b0);
        step(1'b0, C_SKIP, 2'b10, 1'b0, 1'b0);
        skip_req = 1'b1;
        step(1'b1, 64'd9, 2'b01, 1'b0, 1'b0);
        skip_req = 1'b0;
        step(1'b0, C_SKIP, 2'b10, 1'b0, 1'b1);
        step(1'b1, 64'd10, 2'b01, 1'b0, 1'b0);
        step(1'b1, 64'd11, 2'b01, 1'b0, 1'b0);
        step(1'b0, 64'h6400000000000000, 2'b10, 1'b0, 1'b0);

        // Coalesced request in slots 0..2, then re-arm in slot 3
        skip_req = 1'b1;
        step(1'b0, C_SYNC, 2'b10, 1'b1, 1'b0);
        step(1'b0, 64'h2800000000000000, 2'b10, 1'b0, 1'b0);
        step(1'b0, C_SKIP, 2'b10, 1'b0, 1'b0);
        skip_req = 1'b1;
        step(1'b0, C_SKIP, 2'b10, 1'b0, 1'b1);
        skip_req = 1'b0;
        step(1'b0, C_SKIP, 2'b10, 1'b0, 1'b1);
        step(1'b1, 64'd12, 2'b01, 1'b0, 1'b0);
        step(1'b1, 64'd13, 2'b01, 1'b0, 1'b0);
        step(1'b0, 64'h6400000000000000, 2'b10, 1'b0, 1'b0);

        // Mid-frame reset at slot 5 with a skip pending
        step(1'b0, C_SYNC, 2'b10, 1'b1, 1'b0);
        step(1'b0, 64'h2800000000000000, 2'b10, 1'b0, 1'b0);
        step(1'b0, C_SKIP, 2'b10, 1'b0, 1'b0);
        step(1'b1, 64'd14, 2'b01, 1'b0, 1'b0);
        skip_req = 1'b1;
        step(1'b1, 64'd15, 2'b01, 1'b0, 1'b0);
        skip_req = 1'b0;
        rst_n = 1'b0;
        step(1'b0, C_IDLE, 2'b10, 1'b0, 1'b0);
        step(1'b0, C_IDLE, 2'b10, 1'b0, 1'b0);
        rst_n = 1'b1;
        frame(1'b1, 64'd16, 58'h0, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
`default_nettype wire
